delay_sweep_sequencer: RTL and testbench

- Scheduler for the pulse datapath's `delay` parameter. Steps the pump–probe delay through a programmed linear sweep.
- Holds each point for a fixed number of pulse periods. Updates are applied only at period boundaries, so no period ever sees a torn value.
- Sits between `pulse_control` (configuration, `clk` domain) and `pulses` (`clk_pll` domain). It drives `pulses.delay` in place of the raw control-register value.

---
 rtl/delay_sweep_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_delay_sweep_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sweep_sequencer.sv
// rtl/delay_sweep_sequencer.sv - linear pump-probe delay sweep scheduler, clk_pll domain
// Optional settle periods after each delay update: define SWEEP_SETTLE_EN.
module delay_sweep_sequencer #(
    parameter int DW           = 32,
    parameter int CW           = 16,
    parameter int SETTLE_SHOTS = 2
) (
    input  logic          clk_pll,
    input  logic          resetn,
    input  logic          cfg_toggle,
    input  logic [DW-1:0] start_delay,
    input  logic [DW-1:0] step,
    input  logic [CW-1:0] num_points,
    input  logic [CW-1:0] shots_per_point,
    input  logic          run,
    input  logic          period_tick,
    output logic [DW-1:0] delay_out,
    output logic [CW-1:0] point_idx,
    output logic          busy,
    output logic          record_gate,
    output logic          sweep_done
);

    localparam int STW = (SETTLE_SHOTS > 0) ? $clog2(SETTLE_SHOTS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cfg_sync_q;
    logic [2:0]    run_sync_q;
    logic [DW-1:0] start_q, start_d;
    logic [DW-1:0] step_q, step_d;
    logic [CW-1:0] points_q, points_d;
    logic [CW-1:0] shots_q, shots_d;
    logic          load_pend_q, load_pend_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] shot_q, shot_d;
    logic [STW-1:0] settle_q;
`ifdef SWEEP_SETTLE_EN
    logic [STW-1:0] settle_d;
`endif

    logic          cfg_load;
    logic          run_rise;
    logic          run_lvl;
    logic          discard;
    logic [CW-1:0] eff_points;
    logic [CW-1:0] eff_shots;

    // Bit 0/1 form the two-flop synchroniser; bit 2 is the edge-detect history.
    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            cfg_sync_q <= '0;
            run_sync_q <= '0;
        end else begin
            cfg_sync_q <= {cfg_sync_q[1:0], cfg_toggle};
            run_sync_q <= {run_sync_q[1:0], run};
        end
    end

    assign cfg_load = cfg_sync_q[1] ^ cfg_sync_q[2];
    assign run_rise = run_sync_q[1] & ~run_sync_q[2];
    assign run_lvl  = run_sync_q[1];

    // A load arriving together with run_rise is already valid for the zero guard.
    assign eff_points = cfg_load ? num_points : points_q;
    assign eff_shots  = cfg_load ? shots_per_point : shots_q;

`ifdef SWEEP_SETTLE_EN
    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            settle_q <= '0;
        end else begin
            settle_q <= settle_d;
        end
    end
`else
    assign settle_q = '0;
`endif

    assign discard = (settle_q != '0);

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        step_d      = step_q;
        points_d    = points_q;
        shots_d     = shots_q;
        load_pend_d = 1'b0;
        delay_d     = delay_q;
        idx_d       = idx_q;
        shot_d      = shot_q;
`ifdef SWEEP_SETTLE_EN
        settle_d    = settle_q;
`endif

        if (load_pend_q) begin
            delay_d = start_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    start_d     = start_delay;
                    step_d      = step;
                    points_d    = num_points;
                    shots_d     = shots_per_point;
                    load_pend_d = 1'b1;
                end
                if (run_rise && (eff_points != '0) && (eff_shots != '0)) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (!run_lvl) begin
                    state_d = S_IDLE;
                    delay_d = start_q;
                    idx_d   = '0;
                end else if (period_tick) begin
                    state_d  = S_RUN;
                    delay_d  = start_q;
                    idx_d    = '0;
                    shot_d   = '0;
`ifdef SWEEP_SETTLE_EN
                    settle_d = STW'(SETTLE_SHOTS);
`endif
                end
            end
            S_RUN: begin
                if (!run_lvl) begin
                    state_d = S_IDLE;
                    delay_d = start_q;
                    idx_d   = '0;
                end else if (period_tick) begin
                    if (discard) begin
`ifdef SWEEP_SETTLE_EN
                        settle_d = settle_q - STW'(1);
`endif
                    end else if (shot_q < shots_q - CW'(1)) begin
                        shot_d = shot_q + CW'(1);
                    end else if (idx_q == points_q - CW'(1)) begin
                        state_d = S_DONE;
                        delay_d = start_q;
                        idx_d   = '0;
                    end else begin
                        idx_d    = idx_q + CW'(1);
                        delay_d  = delay_q + step_q;
                        shot_d   = '0;
`ifdef SWEEP_SETTLE_EN
                        settle_d = STW'(SETTLE_SHOTS);
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            start_q     <= '0;
            step_q      <= '0;
            points_q    <= '0;
            shots_q     <= '0;
            load_pend_q <= 1'b0;
            delay_q     <= '0;
            idx_q       <= '0;
            shot_q      <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            step_q      <= step_d;
            points_q    <= points_d;
            shots_q     <= shots_d;
            load_pend_q <= load_pend_d;
            delay_q     <= delay_d;
            idx_q       <= idx_d;
            shot_q      <= shot_d;
        end
    end

    assign delay_out   = delay_q;
    assign point_idx   = idx_q;
    assign busy        = (state_q == S_ARM) || (state_q == S_RUN);
    assign record_gate = (state_q == S_RUN) && !discard;
    assign sweep_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_delay_sweep_sequencer.sv
// tb/tb_delay_sweep_sequencer.sv - self-checking bench for delay_sweep_sequencer
`timescale 1ns/1ps
module tb_delay_sweep_sequencer;

`ifdef SWEEP_SETTLE_EN
    localparam int SETTLE = 2;
`else
    localparam int SETTLE = 0;
`endif

    logic        clk_pll = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_toggle = 1'b0;
    logic [31:0] start_delay = '0;
    logic [31:0] step = '0;
    logic [15:0] num_points = '0;
    logic [15:0] shots_per_point = '0;
    logic        run = 1'b0;
    logic        period_tick = 1'b0;
    logic [31:0] delay_out;
    logic [15:0] point_idx;
    logic        busy;
    logic        record_gate;
    logic        sweep_done;

    delay_sweep_sequencer #(.DW(32), .CW(16), .SETTLE_SHOTS(2)) dut (
        .clk_pll(clk_pll), .resetn(resetn), .cfg_toggle(cfg_toggle),
        .start_delay(start_delay), .step(step), .num_points(num_points),
        .shots_per_point(shots_per_point), .run(run), .period_tick(period_tick),
        .delay_out(delay_out), .point_idx(point_idx), .busy(busy),
        .record_gate(record_gate), .sweep_done(sweep_done)
    );

    always #5 clk_pll = ~clk_pll;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int done_base;
    int busy_base;
    int done_tick_obs;
    logic [31:0] last_d_obs;

    always @(negedge clk_pll) begin
        if (sweep_done) done_cnt <= done_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic load_cfg(input logic [31:0] st, sp, input int p, s);
        @(negedge clk_pll);
        start_delay = st;
        step = sp;
        num_points = 16'(p);
        shots_per_point = 16'(s);
        cfg_toggle = ~cfg_toggle;
        repeat (6) @(negedge clk_pll);
        #1;
    endtask

    task automatic set_run(input logic v);
        @(negedge clk_pll);
        run = v;
        repeat (5) @(negedge clk_pll);
        #1;
    endtask

    task automatic pulse_tick(input int gap);
        @(negedge clk_pll);
        period_tick = 1'b1;
        @(negedge clk_pll);
        period_tick = 1'b0;
        repeat (gap - 1) @(negedge clk_pll);
        #1;
    endtask

    // Reference: tick k (k=0 is the ARM tick) lies in point k/per; tick p*per completes.
    task automatic do_sweep(input logic [31:0] st, sp, input int p, s, gap, k_lo, k_hi);
        int per, total, pt;
        per = s + SETTLE;
        total = p * per;
        if (k_lo == 0) begin
            done_base = done_cnt;
            done_tick_obs = -1;
        end
        for (int k = k_lo; k <= k_hi; k++) begin
            pulse_tick(gap);
            if (k < total) begin
                pt = k / per;
                chk("sweep_delay", delay_out, st + 32'(pt) * sp);
                chk("sweep_idx", 32'(point_idx), 32'(pt));
                chk("sweep_gate", 32'(record_gate), 32'((k % per) >= SETTLE));
                chk("sweep_busy", 32'(busy), 32'd1);
                chk("sweep_no_early_done", 32'(done_cnt), 32'(done_base));
                if (k == total - 1) last_d_obs = delay_out;
            end else begin
                chk("sweep_done_once", 32'(done_cnt), 32'(done_base + 1));
                chk("sweep_end_delay", delay_out, st);
                chk("sweep_end_idx", 32'(point_idx), 32'd0);
                chk("sweep_end_busy", 32'(busy), 32'd0);
                if (done_cnt == done_base + 1) done_tick_obs = k;
            end
        end
    endtask

    typedef struct {
        logic [31:0] st;
        logic [31:0] sp;
        int          pts;
        int          shots;
        logic        exp_busy;
        logic [31:0] exp_last;
        int          exp_done;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] rst_v, rsp_v;
        int rp, rs, rg, ra, rtot;

        tbl[0] = '{32'd100,        32'd20,         4, 3, 1'b1, 32'd160,        12 + 4 * SETTLE};
        tbl[1] = '{32'd10,         32'hFFFF_FFFC,  4, 1, 1'b1, 32'hFFFF_FFFE,  4 + 4 * SETTLE};
        tbl[2] = '{32'd55,         32'd7,          0, 3, 1'b0, 32'd0,          0};
        tbl[3] = '{32'd66,         32'd1,          2, 0, 1'b0, 32'd0,          0};
        tbl[4] = '{32'hFFFF_FFFF,  32'd1,          2, 2, 1'b1, 32'd0,          4 + 2 * SETTLE};
        tbl[5] = '{32'd7,          32'd3,          1, 1, 1'b1, 32'd7,          1 + 1 * SETTLE};

        repeat (3) @(negedge clk_pll);
        #1;
        chk("rst_delay", delay_out, 32'd0);
        chk("rst_idx", 32'(point_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gate", 32'(record_gate), 32'd0);
        chk("rst_done", 32'(sweep_done), 32'd0);
        @(negedge clk_pll);
        resetn = 1'b1;

        // Table: basic, signed step, zero guards, wrap, single point
        for (int i = 0; i < 6; i++) begin
            load_cfg(tbl[i].st, tbl[i].sp, tbl[i].pts, tbl[i].shots);
            chk("tbl_load_delay", delay_out, tbl[i].st);
            busy_base = busy_cnt;
            done_base = done_cnt;
            set_run(1'b1);
            chk("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
            if (tbl[i].exp_busy) begin
                do_sweep(tbl[i].st, tbl[i].sp, tbl[i].pts, tbl[i].shots,
                         (i == 0) ? 50 : 4, 0, tbl[i].pts * (tbl[i].shots + SETTLE));
                chk("tbl_last_delay", last_d_obs, tbl[i].exp_last);
                chk("tbl_done_tick", 32'(done_tick_obs), 32'(tbl[i].exp_done));
            end else begin
                pulse_tick(4);
                pulse_tick(4);
                chk("zero_busy_never", 32'(busy_cnt), 32'(busy_base));
                chk("zero_delay", delay_out, tbl[i].st);
                chk("zero_no_done", 32'(done_cnt), 32'(done_base));
            end
            set_run(1'b0);
        end

        // Abort after 5 ticks, then re-raise, then held-high run must not re-trigger
        load_cfg(32'd100, 32'd20, 4, 3);
        set_run(1'b1);
        do_sweep(32'd100, 32'd20, 4, 3, 5, 0, 4);
        @(negedge clk_pll);
        run = 1'b0;
        repeat (4) @(negedge clk_pll);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_delay", delay_out, 32'd100);
        chk("abort_idx", 32'(point_idx), 32'd0);
        chk("abort_gate", 32'(record_gate), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'(done_base));
        set_run(1'b1);
        chk("rearm_busy", 32'(busy), 32'd1);
        do_sweep(32'd100, 32'd20, 4, 3, 4, 0, 4 * (3 + SETTLE));
        busy_base = busy_cnt;
        done_base = done_cnt;
        repeat (10) @(negedge clk_pll);
        pulse_tick(4);
        pulse_tick(4);
        chk("held_run_no_busy", 32'(busy_cnt), 32'(busy_base));
        chk("held_run_no_done", 32'(done_cnt), 32'(done_base));
        set_run(1'b0);

        // Config toggle mid-RUN is ignored; a later toggle in IDLE applies
        load_cfg(32'd100, 32'd20, 4, 3);
        set_run(1'b1);
        do_sweep(32'd100, 32'd20, 4, 3, 4, 0, 4);
        load_cfg(32'd500, 32'd20, 4, 3);
        do_sweep(32'd100, 32'd20, 4, 3, 4, 5, 4 * (3 + SETTLE));
        chk("midcfg_final_delay", delay_out, 32'd100);
        set_run(1'b0);
        load_cfg(32'd500, 32'd20, 4, 3);
        chk("idle_cfg_delay", delay_out, 32'd500);

        // Randomised full sweeps and randomised aborts against the reference
        for (int it = 0; it < 16; it++) begin
            rst_v = $urandom;
            rsp_v = $urandom;
            rp = $urandom_range(1, 5);
            rs = $urandom_range(1, 4);
            rg = $urandom_range(3, 8);
            rtot = rp * (rs + SETTLE);
            load_cfg(rst_v, rsp_v, rp, rs);
            chk("rnd_load_delay", delay_out, rst_v);
            set_run(1'b1);
            if (it % 2 == 0) begin
                do_sweep(rst_v, rsp_v, rp, rs, rg, 0, rtot);
            end else begin
                ra = $urandom_range(1, rtot);
                do_sweep(rst_v, rsp_v, rp, rs, rg, 0, ra - 1);
                @(negedge clk_pll);
                run = 1'b0;
                repeat (4) @(negedge clk_pll);
                #1;
                chk("rnd_abort_busy", 32'(busy), 32'd0);
                chk("rnd_abort_delay", delay_out, rst_v);
                chk("rnd_abort_no_done", 32'(done_cnt), 32'(done_base));
            end
            set_run(1'b0);
        end

        // Reset in the middle of a sweep
        load_cfg(32'd300, 32'd9, 3, 2);
        set_run(1'b1);
        do_sweep(32'd300, 32'd9, 3, 2, 4, 0, 2 + SETTLE);
        @(negedge clk_pll);
        resetn = 1'b0;
        run = 1'b0;
        cfg_toggle = 1'b0;
        #1;
        chk("midrst_delay", delay_out, 32'd0);
        chk("midrst_idx", 32'(point_idx), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_gate", 32'(record_gate), 32'd0);
        repeat (2) @(negedge clk_pll);
        resetn = 1'b1;
        repeat (5) @(negedge clk_pll);
        #1;
        chk("postrst_delay", delay_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
